// File: rtl/pb_edge_pkg.sv
// Shared types for the pushbutton front end: per-channel FSM states and
// edge-mode encoding, plus the decode of edge_mode into per-edge enables.
package pb_edge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        HELD,
        REL_DB
    } pb_state_t;

    typedef enum logic [1:0] {
        EM_RISE,
        EM_FALL,
        EM_BOTH,
        EM_NONE
    } edge_mode_t;

    function automatic logic em_rise_en(input edge_mode_t m);
        return (m == EM_RISE) || (m == EM_BOTH);
    endfunction

    function automatic logic em_fall_en(input edge_mode_t m);
        return (m == EM_FALL) || (m == EM_BOTH);
    endfunction

endpackage

// File: rtl/pb_chan.sv
// One pushbutton channel: synchroniser, debounce/hold FSM with a shared
// counter, and registered level/rise/fall/held/evt outputs.
//
//   state    | meaning
//   IDLE     | released, waiting for synchronised high
//   PRESS_DB | counting stable high samples before accepting a press
//   PRESSED  | accepted press, counting toward long-press
//   HELD     | long-press reached, counter frozen
//   REL_DB   | counting stable low samples before accepting a release
module pb_chan
    import pb_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 28,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic RST,
    input  logic pb_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic held_o,
    output logic evt_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               DB_ONE    = (DB_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   raw_s;

    pb_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             was_held_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             held_q;
    logic             evt_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pb_i};
    assign raw_s  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            was_held_q <= 1'b0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            held_q     <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (raw_s) begin
                        if (DB_ONE) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                            evt_q   <= rise_en_i;
                        end else begin
                            state_q <= PRESS_DB;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!raw_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        evt_q   <= rise_en_i;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED, HELD: begin
                    // Release is checked first so it wins over reaching the hold count.
                    if (!raw_s) begin
                        was_held_q <= (state_q == HELD);
                        if (DB_ONE) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            held_q  <= 1'b0;
                            fall_q  <= 1'b1;
                            evt_q   <= fall_en_i;
                        end else begin
                            state_q <= REL_DB;
                            cnt_q   <= CNT_ONE;
                        end
                    end else if (state_q == PRESSED) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q <= HELD;
                            held_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                REL_DB: begin
                    if (raw_s) begin
                        state_q <= was_held_q ? HELD : PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        held_q  <= 1'b0;
                        fall_q  <= 1'b1;
                        evt_q   <= fall_en_i;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign held_o  = held_q;
    assign evt_o   = evt_q;

endmodule

// File: rtl/pb_edge_debounce.sv
// Multi-channel pushbutton front end: NCH debounced channels, edge_mode
// event selection and a lowest-index priority encoder over the events.
module pb_edge_debounce
    import pb_edge_pkg::*;
#(
    parameter  int NCH         = 21,
    parameter  int SYNC_STAGES = 2,
    parameter  int DB_CYCLES   = 28,
    parameter  int HOLD_CYCLES = 1000,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1),
    localparam int IDX_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [NCH-1:0]   pb_in,
    input  logic [1:0]       edge_mode,
    output logic [NCH-1:0]   level,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [NCH-1:0]   held,
    output logic [NCH-1:0]   evt,
    output logic             any_evt,
    output logic [IDX_W-1:0] evt_idx
);

    edge_mode_t em;
    logic       rise_en;
    logic       fall_en;

    assign em      = edge_mode_t'(edge_mode);
    assign rise_en = em_rise_en(em);
    assign fall_en = em_fall_en(em);

    // Each channel registers evt alongside its pulse, so edge_mode is
    // sampled on the same edge that generates rise/fall.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pb_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk      (clk),
            .RST      (RST),
            .pb_i     (pb_in[g]),
            .rise_en_i(rise_en),
            .fall_en_i(fall_en),
            .level_o  (level[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g]),
            .held_o   (held[g]),
            .evt_o    (evt[g])
        );
    end

    assign any_evt = |evt;

    always_comb begin
        evt_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (evt[i]) begin
                evt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_pb_edge_debounce.sv
// Bench for pb_edge_debounce: a 4-channel build and a 1-channel DB_CYCLES=1
// build, with expected rise/fall pulses tracked in a cycle-stamped queue.
module tb_pb_edge_debounce;

    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int DB  = 4;
    localparam int H   = 20;
    localparam int LAT = S + DB;
    localparam int H1  = 8;

    logic           clk = 1'b0;
    logic           RST = 1'b1;
    logic [NCH-1:0] pb_in = '0;
    logic [1:0]     edge_mode = 2'b00;
    logic [NCH-1:0] level, rise, fall, held, evt;
    logic           any_evt;
    logic [1:0]     evt_idx;

    logic [0:0]     pb_in1 = 1'b0;
    logic [0:0]     level1, rise1, fall1, held1, evt1;
    logic           any_evt1;
    logic [0:0]     evt_idx1;

    pb_edge_debounce #(.NCH(NCH), .SYNC_STAGES(S), .DB_CYCLES(DB), .HOLD_CYCLES(H)) u_dut (
        .clk(clk), .RST(RST), .pb_in(pb_in), .edge_mode(edge_mode),
        .level(level), .rise(rise), .fall(fall), .held(held), .evt(evt),
        .any_evt(any_evt), .evt_idx(evt_idx)
    );

    pb_edge_debounce #(.NCH(1), .SYNC_STAGES(S), .DB_CYCLES(1), .HOLD_CYCLES(H1)) u_dut1 (
        .clk(clk), .RST(RST), .pb_in(pb_in1), .edge_mode(edge_mode),
        .level(level1), .rise(rise1), .fall(fall1), .held(held1), .evt(evt1),
        .any_evt(any_evt1), .evt_idx(evt_idx1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dut;
        int ch;
        bit is_rise;
        int at;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < 2; k++) begin
                    logic p;
                    int   idx;
                    if (d == 0) p = (k == 1) ? rise[ch] : fall[ch];
                    else        p = (ch == 0) ? ((k == 1) ? rise1[0] : fall1[0]) : 1'b0;
                    if (p === 1'b1) begin
                        idx = -1;
                        foreach (sb_q[j])
                            if (idx < 0 && sb_q[j].dut == d && sb_q[j].ch == ch && sb_q[j].is_rise == (k == 1))
                                idx = j;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL pulse_unexpected dut=%0d ch=%0d rise=%0d at cycle %0d, no pulse required", d, ch, k, cyc);
                        end else begin
                            if (sb_q[idx].at != cyc) begin
                                errors++;
                                $display("FAIL pulse_cycle dut=%0d ch=%0d rise=%0d got cycle %0d required %0d", d, ch, k, cyc, sb_q[idx].at);
                            end
                            sb_q.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        pb_in = '0;
        pb_in1 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({level, rise, fall, held, evt} !== '0 || any_evt !== 1'b0 || evt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%b/%b/%b/%b any=%b idx=%0d required all 0",
                     level, rise, fall, held, evt, any_evt, evt_idx);
        end
        checks++;
        if ({level1, rise1, fall1, held1, evt1, any_evt1, evt_idx1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs_db1 got %b required 0",
                     {level1, rise1, fall1, held1, evt1, any_evt1, evt_idx1});
        end
        tick();
        RST = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_press_hold();
        int c, d;
        edge_mode = 2'b00;
        tick();
        c = cyc;
        pb_in[2] = 1'b1;
        sb_q.push_back('{dut: 0, ch: 2, is_rise: 1'b1, at: c + LAT});
        wait_neg(c + LAT - 1);
        checks++;
        if (level[2] !== 1'b0) begin errors++; $display("FAIL press_level_early got %b required 0", level[2]); end
        wait_neg(c + LAT);
        checks++;
        if (level[2] !== 1'b1 || held[2] !== 1'b0) begin
            errors++; $display("FAIL press_level got level=%b held=%b required 1/0", level[2], held[2]);
        end
        wait_neg(c + LAT + H - 1);
        checks++;
        if (held[2] !== 1'b0) begin errors++; $display("FAIL held_early got %b required 0", held[2]); end
        wait_neg(c + LAT + H);
        checks++;
        if (held[2] !== 1'b1 || level[2] !== 1'b1) begin
            errors++; $display("FAIL held_entry got held=%b level=%b required 1/1", held[2], level[2]);
        end
        tick();
        d = cyc;
        pb_in[2] = 1'b0;
        sb_q.push_back('{dut: 0, ch: 2, is_rise: 1'b0, at: d + LAT});
        wait_neg(d + LAT - 1);
        checks++;
        if (held[2] !== 1'b1 || level[2] !== 1'b1) begin
            errors++; $display("FAIL release_db_held got held=%b level=%b required 1/1", held[2], level[2]);
        end
        wait_neg(d + LAT);
        checks++;
        if (held[2] !== 1'b0 || level[2] !== 1'b0) begin
            errors++; $display("FAIL release_level got held=%b level=%b required 0/0", held[2], level[2]);
        end
        wait_neg(d + LAT + 2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL press_hold_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_bounce();
        int c;
        logic bad;
        tick();
        c = cyc;
        pb_in[1] = 1'b1;
        repeat (3) tick();
        pb_in[1] = 1'b0;
        tick();
        pb_in[1] = 1'b1;
        repeat (3) tick();
        pb_in[1] = 1'b0;
        bad = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (level[1] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL bounce_level got level[1]=1 at some cycle required 0 throughout"); end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL bounce_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_release_bounce();
        int c, d;
        logic bad;
        tick();
        c = cyc;
        pb_in[2] = 1'b1;
        sb_q.push_back('{dut: 0, ch: 2, is_rise: 1'b1, at: c + LAT});
        wait_neg(c + LAT + H);
        checks++;
        if (held[2] !== 1'b1) begin errors++; $display("FAIL rb_held_entry got %b required 1", held[2]); end
        tick();
        d = cyc;
        pb_in[2] = 1'b0;
        tick();
        tick();
        pb_in[2] = 1'b1;
        tick();
        pb_in[2] = 1'b0;
        sb_q.push_back('{dut: 0, ch: 2, is_rise: 1'b0, at: d + 3 + LAT});
        bad = 1'b0;
        for (int t = d + 3; t <= d + 8; t++) begin
            wait_neg(t);
            if (held[2] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rb_held_through_bounce got held=0 during bounce required 1"); end
        wait_neg(d + 9);
        checks++;
        if (held[2] !== 1'b0 || level[2] !== 1'b0) begin
            errors++; $display("FAIL rb_final got held=%b level=%b required 0/0", held[2], level[2]);
        end
        wait_neg(d + 11);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL rb_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_edge_mode();
        int c, d;
        logic [3:0] exp_r, exp_f;
        for (int m = 0; m < 4; m++) begin
            edge_mode = 2'(m);
            exp_r = (m == 0 || m == 2) ? 4'b1001 : 4'b0000;
            exp_f = (m == 1 || m == 2) ? 4'b1001 : 4'b0000;
            tick();
            c = cyc;
            pb_in[0] = 1'b1;
            pb_in[3] = 1'b1;
            sb_q.push_back('{dut: 0, ch: 0, is_rise: 1'b1, at: c + LAT});
            sb_q.push_back('{dut: 0, ch: 3, is_rise: 1'b1, at: c + LAT});
            wait_neg(c + LAT);
            checks++;
            if (evt !== exp_r || any_evt !== (exp_r != 0) || evt_idx !== 2'd0) begin
                errors++; $display("FAIL em%0d_press got evt=%b any=%b idx=%0d required evt=%b any=%b idx=0",
                                   m, evt, any_evt, evt_idx, exp_r, (exp_r != 0));
            end
            wait_neg(c + LAT + 1);
            checks++;
            if (evt !== 4'b0000 || any_evt !== 1'b0) begin
                errors++; $display("FAIL em%0d_press_width got evt=%b any=%b required 0", m, evt, any_evt);
            end
            tick();
            d = cyc;
            pb_in[0] = 1'b0;
            pb_in[3] = 1'b0;
            sb_q.push_back('{dut: 0, ch: 0, is_rise: 1'b0, at: d + LAT});
            sb_q.push_back('{dut: 0, ch: 3, is_rise: 1'b0, at: d + LAT});
            wait_neg(d + LAT);
            checks++;
            if (evt !== exp_f || any_evt !== (exp_f != 0) || evt_idx !== 2'd0) begin
                errors++; $display("FAIL em%0d_release got evt=%b any=%b idx=%0d required evt=%b any=%b idx=0",
                                   m, evt, any_evt, evt_idx, exp_f, (exp_f != 0));
            end
            wait_neg(d + LAT + 2);
            checks++;
            if (sb_q.size() != 0) begin
                errors++; $display("FAIL em%0d_pending got %0d outstanding pulses required 0", m, sb_q.size()); sb_q.delete();
            end
        end
        // Priority encoder with non-zero winners: ch1+ch3 together, then released apart.
        edge_mode = 2'b10;
        tick();
        c = cyc;
        pb_in[1] = 1'b1;
        pb_in[3] = 1'b1;
        sb_q.push_back('{dut: 0, ch: 1, is_rise: 1'b1, at: c + LAT});
        sb_q.push_back('{dut: 0, ch: 3, is_rise: 1'b1, at: c + LAT});
        wait_neg(c + LAT);
        checks++;
        if (evt !== 4'b1010 || evt_idx !== 2'd1 || any_evt !== 1'b1) begin
            errors++; $display("FAIL prio_both got evt=%b idx=%0d any=%b required 1010 idx=1 any=1", evt, evt_idx, any_evt);
        end
        tick();
        d = cyc;
        pb_in[1] = 1'b0;
        sb_q.push_back('{dut: 0, ch: 1, is_rise: 1'b0, at: d + LAT});
        wait_neg(d + LAT);
        checks++;
        if (evt !== 4'b0010 || evt_idx !== 2'd1) begin
            errors++; $display("FAIL prio_ch1 got evt=%b idx=%0d required 0010 idx=1", evt, evt_idx);
        end
        tick();
        d = cyc;
        pb_in[3] = 1'b0;
        sb_q.push_back('{dut: 0, ch: 3, is_rise: 1'b0, at: d + LAT});
        wait_neg(d + LAT);
        checks++;
        if (evt !== 4'b1000 || evt_idx !== 2'd3 || any_evt !== 1'b1) begin
            errors++; $display("FAIL prio_ch3 got evt=%b idx=%0d any=%b required 1000 idx=3 any=1", evt, evt_idx, any_evt);
        end
        wait_neg(d + LAT + 2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL prio_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
        edge_mode = 2'b00;
    endtask

    task automatic test_reset_mid_press();
        int c, r, d;
        tick();
        c = cyc;
        pb_in[0] = 1'b1;
        sb_q.push_back('{dut: 0, ch: 0, is_rise: 1'b1, at: c + LAT});
        wait_neg(c + LAT + H);
        checks++;
        if (held[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_held got %b required 1", held[0]); end
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        r = cyc;
        wait_neg(r);
        checks++;
        if ({level, rise, fall, held, evt} !== '0 || any_evt !== 1'b0 || evt_idx !== 2'd0) begin
            errors++; $display("FAIL rst_mid_outputs got %b/%b/%b/%b/%b any=%b idx=%0d required all 0",
                               level, rise, fall, held, evt, any_evt, evt_idx);
        end
        sb_q.push_back('{dut: 0, ch: 0, is_rise: 1'b1, at: r + LAT});
        wait_neg(r + LAT - 1);
        checks++;
        if (level[0] !== 1'b0) begin errors++; $display("FAIL rst_relatch_early got level=%b required 0", level[0]); end
        wait_neg(r + LAT);
        checks++;
        if (level[0] !== 1'b1) begin errors++; $display("FAIL rst_relatch got level=%b required 1", level[0]); end
        tick();
        d = cyc;
        pb_in[0] = 1'b0;
        sb_q.push_back('{dut: 0, ch: 0, is_rise: 1'b0, at: d + LAT});
        wait_neg(d + LAT + 2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL rst_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_db1();
        int c, d;
        logic bad;
        tick();
        c = cyc;
        pb_in1 = 1'b1;
        tick();
        pb_in1 = 1'b0;
        sb_q.push_back('{dut: 1, ch: 0, is_rise: 1'b1, at: c + S + 1});
        sb_q.push_back('{dut: 1, ch: 0, is_rise: 1'b0, at: c + S + 2});
        wait_neg(c + S + 1);
        checks++;
        if (level1 !== 1'b1 || evt1 !== 1'b1 || any_evt1 !== 1'b1) begin
            errors++; $display("FAIL db1_pulse_rise got level=%b evt=%b any=%b required 1/1/1", level1, evt1, any_evt1);
        end
        wait_neg(c + S + 2);
        checks++;
        if (level1 !== 1'b0) begin errors++; $display("FAIL db1_pulse_fall got level=%b required 0", level1); end
        tick();
        c = cyc;
        pb_in1 = 1'b1;
        sb_q.push_back('{dut: 1, ch: 0, is_rise: 1'b1, at: c + S + 1});
        wait_neg(c + S + H1);
        checks++;
        if (held1 !== 1'b0) begin errors++; $display("FAIL db1_held_early got %b required 0", held1); end
        wait_neg(c + S + 1 + H1);
        checks++;
        if (held1 !== 1'b1) begin errors++; $display("FAIL db1_held got %b required 1", held1); end
        bad = 1'b0;
        for (int t = 0; t < 10000; t++) begin
            @(negedge clk);
            if (held1 !== 1'b1 || level1 !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL db1_long_hold got held/level dropped during 10000 cycles required 1"); end
        tick();
        d = cyc;
        pb_in1 = 1'b0;
        sb_q.push_back('{dut: 1, ch: 0, is_rise: 1'b0, at: d + S + 1});
        wait_neg(d + S + 1);
        checks++;
        if (held1 !== 1'b0 || level1 !== 1'b0) begin
            errors++; $display("FAIL db1_release got held=%b level=%b required 0/0", held1, level1);
        end
        wait_neg(d + S + 3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL db1_pending got %0d outstanding pulses required 0", sb_q.size()); sb_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_press_hold();
        test_bounce();
        test_release_bounce();
        test_edge_mode();
        test_reset_mid_press();
        test_db1();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_edge_debounce.md
Name: pb_edge_debounce

Overview:
- Multi-channel pushbutton front end. Each channel has a synchroniser, a debounce filter, and rise/fall edge pulses with a selectable edge mode.
- Each channel also has a long-press ("held") detect.
- A priority encoder reports the lowest-numbered channel with an event.
- Sits between the raw pb pins and downstream counters/FSMs, and replaces ad-hoc per-button sync/edge logic.

Parameters:
- NCH, 21, number of button channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DB_CYCLES, 28, consecutive stable synchronised cycles required to accept a level change (≥1)
- HOLD_CYCLES, 1000, cycles in PRESSED before entering HELD (>DB_CYCLES)
- CNT_W, $clog2(HOLD_CYCLES+1), per-channel counter width (derived)
- IDX_W, (NCH>1 ? $clog2(NCH) : 1), width of evt_idx (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- pb_in  in  NCH  raw asynchronous button inputs
- edge_mode  in  2  event select: 00 rise, 01 fall, 10 both, 11 none
- level  out  NCH  debounced level per channel
- rise  out  NCH  1-cycle pulse on accepted press
- fall  out  NCH  1-cycle pulse on accepted release
- held  out  NCH  high while channel is in HELD or its release debounce
- evt  out  NCH  rise/fall filtered by edge_mode
- any_evt  out  1  OR of evt
- evt_idx  out  IDX_W  lowest index i with evt[i]=1; 0 when any_evt=0

Behaviour:

Reset and clocking:
- Reset is synchronous and active-high. The port is named RST; the single clock is clk.
- While RST=1 at a clk edge: all sync flops=0, all channels IDLE, counters=0, outputs level/rise/fall/held/evt=0, any_evt=0, evt_idx=0.

Synchronisation:
- raw_s[i] is the output of the last of the SYNC_STAGES flops.
- Per-channel FSM states: IDLE, PRESS_DB, PRESSED, HELD, REL_DB. A was_held flag records the source of REL_DB.

State transitions:
- IDLE: if raw_s=1, go to PRESS_DB with cnt=1. For DB_CYCLES=1, go directly to PRESSED with rise registered.
- PRESS_DB:
  - raw_s=0: back to IDLE, cnt=0. No pulse is produced.
  - raw_s=1 and cnt=DB_CYCLES-1: go to PRESSED, cnt=0, rise=1 for the next cycle.
  - Otherwise: cnt+1.
- PRESSED: level=1.
  - raw_s=0: go to REL_DB, cnt=1, was_held=0.
  - cnt=HOLD_CYCLES-1: go to HELD.
  - Otherwise: cnt+1.
  - Release takes priority over hold when both occur in the same cycle.
- HELD: level=1, held=1. If raw_s=0, go to REL_DB, cnt=1, was_held=1.
- REL_DB:
  - raw_s=1 (bounce): return to HELD if was_held, else PRESSED with cnt=0. No pulses are produced.
  - raw_s=0 and cnt=DB_CYCLES-1: go to IDLE, level=0, held=0, fall=1 for the next cycle.

Outputs and timing:
- All per-channel outputs are registered.
- rise/fall last exactly one cycle.
- Latency: pin high first sampled at edge k → rise high during the cycle after edge k+SYNC_STAGES+DB_CYCLES-1. Release latency is symmetric.
- Counters saturate and never wrap: the HELD state stops counting.
- evt[i] is registered, in the same cycle as rise/fall:
  - edge_mode=00: evt = rise
  - edge_mode=01: evt = fall
  - edge_mode=10: evt = rise|fall
  - edge_mode=11: evt = 0
- edge_mode is sampled at the cycle the pulse is generated.
- any_evt and evt_idx are combinational from registered evt, so they are valid in the same cycle as evt.
- Simultaneous events: all evt bits assert; evt_idx is the lowest set index.

Reset and edge cases:
- RST mid-press: state is lost and no fall is emitted. A pin still high after reset deasserts is treated as a new press, with full latency.
- A pulse shorter than DB_CYCLES synchronised cycles produces no output.

Decomposition:
- Package pb_edge_pkg:
  - typedef enum logic [2:0] pb_state_t {IDLE, PRESS_DB, PRESSED, HELD, REL_DB}
  - typedef enum logic [1:0] edge_mode_t {EM_RISE, EM_FALL, EM_BOTH, EM_NONE}
- Sub-module pb_chan: one channel, containing the synchroniser, FSM and counter. Outputs level/rise/fall/held; counter parameters are passed through.
- Top level: generate-loop of NCH pb_chan instances, plus the edge_mode filter and priority encoder.

Test Plan:
1. NCH=4, SYNC_STAGES=2, DB_CYCLES=4, HOLD_CYCLES=20. Raise pb_in[2] at edge 10 and hold it → rise[2] high for exactly one cycle after edge 15, level[2]=1 from then on, held[2]=1 after a further 20 cycles. Drop the pin → fall[2] pulse 5 cycles later, level=held=0.
2. Bounce: pb_in[1] high for 3 cycles, low 1, high 3, then low → no rise, no fall, level[1] stays 0 throughout.
3. Release bounce from HELD: pin low 2 cycles, high 1, then low → held stays 1 through the bounce, a single fall after the final 4 stable low cycles.
4. edge_mode sweep on channels 0 and 3 pressed on the same edge:
   - 00: evt=4'b1001, any_evt=1, evt_idx=0
   - 01: no evt on press, evt on release
   - 11: evt=0 always, while rise/fall still pulse
5. RST=1 for one cycle while channel 0 is in HELD with the pin still high → next cycle all outputs 0. rise[0] reappears exactly 6 cycles after reset release, and no fall pulse is ever emitted.
6. DB_CYCLES=1 build: a 1-cycle synchronised pulse gives rise then fall on consecutive transitions. Counters never wrap past HOLD_CYCLES across 10,000 cycles held.
